// File: rtl/rob_walk_ctrl.sv
// rob_walk_ctrl
//   Rename-history buffer kept in ROB order plus the recovery sequencer that
//   feeds the speculative RAT. Every renamed instruction records
//   {need_to_wb, lrd, prd}, at most two per cycle, and entries retire at the
//   head at up to two per cycle. A flush runs OVERWRITE_RAT for one cycle
//   (the RAT restores from the arch RAT) and then WALKING, which replays the
//   surviving uncommitted renames oldest-first, two per cycle, before the
//   sequencer returns to IDLE.
//
// Ports
//   clock, reset_n               clock; asynchronous active-low reset
//   enq0_* / enq1_*              rename slots (slot 1 is program-younger)
//   enq_ready                    IDLE and at least two free entries
//   enq_tail_ptr                 pointer that slot 0 will occupy (robid)
//   commit_cnt                   entries retired at the head this cycle (0..2)
//   flush_valid, flush_ptr       squash everything from flush_ptr to the tail
//   rob_state                    0 IDLE, 1 OVERWRITE_RAT, 2 WALKING
//   rob_walk0_* / rob_walk1_*    registered walk slots, slot 0 older
//   walk_busy                    rob_state != IDLE
module rob_walk_ctrl #(
  parameter int unsigned ROB_DEPTH = 64,
  parameter int unsigned PREG_W    = 6,
  parameter int unsigned LREG_W    = 5,
  parameter int unsigned PTR_W     = $clog2(ROB_DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enq0_valid,
  input  logic              enq0_need_to_wb,
  input  logic [LREG_W-1:0] enq0_lrd,
  input  logic [PREG_W-1:0] enq0_prd,
  input  logic              enq1_valid,
  input  logic              enq1_need_to_wb,
  input  logic [LREG_W-1:0] enq1_lrd,
  input  logic [PREG_W-1:0] enq1_prd,
  output logic              enq_ready,
  output logic [PTR_W-1:0]  enq_tail_ptr,
  input  logic [1:0]        commit_cnt,
  input  logic              flush_valid,
  input  logic [PTR_W-1:0]  flush_ptr,
  output logic [1:0]        rob_state,
  output logic              rob_walk0_valid,
  output logic [LREG_W-1:0] rob_walk0_lrd,
  output logic [PREG_W-1:0] rob_walk0_prd,
  output logic              rob_walk1_valid,
  output logic [LREG_W-1:0] rob_walk1_lrd,
  output logic [PREG_W-1:0] rob_walk1_prd,
  output logic              walk_busy
);

  localparam int unsigned      IDX_W      = PTR_W - 1;
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_TWO    = PTR_W'(2);
  localparam logic [PTR_W-1:0] CNT_ROOM_2 = PTR_W'(ROB_DEPTH - 2);

  typedef enum logic [1:0] {
    ST_IDLE          = 2'd0,
    ST_OVERWRITE_RAT = 2'd1,
    ST_WALKING       = 2'd2
  } state_e;

  typedef struct packed {
    logic              need_to_wb;
    logic [LREG_W-1:0] lrd;
    logic [PREG_W-1:0] prd;
  } entry_t;

  entry_t hist_mem [ROB_DEPTH];

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W-1:0]  walk_ptr_q, walk_ptr_d;
  logic [PTR_W-1:0]  walk_end_q, walk_end_d;
  logic              walk0_valid_q, walk0_valid_d;
  logic [LREG_W-1:0] walk0_lrd_q, walk0_lrd_d;
  logic [PREG_W-1:0] walk0_prd_q, walk0_prd_d;
  logic              walk1_valid_q, walk1_valid_d;
  logic [LREG_W-1:0] walk1_lrd_q, walk1_lrd_d;
  logic [PREG_W-1:0] walk1_prd_q, walk1_prd_d;

  logic [PTR_W-1:0]  count;
  logic [PTR_W-1:0]  head_commit;
  logic [PTR_W-1:0]  tail_plus1;
  logic [PTR_W-1:0]  walk_next1;
  logic              enq_fire;
  entry_t            ent0, ent1;

  assign count       = tail_q - head_q;
  assign head_commit = head_q + PTR_W'(commit_cnt);
  assign tail_plus1  = tail_q + PTR_ONE;
  // A flush in IDLE takes priority over enqueue in the same cycle.
  assign enq_fire    = (state_q == ST_IDLE) && !flush_valid;

  // Storage contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clock) begin
    if (enq_fire && enq0_valid) begin
      hist_mem[tail_q[IDX_W-1:0]] <= '{need_to_wb: enq0_need_to_wb,
                                       lrd: enq0_lrd, prd: enq0_prd};
    end
    if (enq_fire && enq1_valid) begin
      hist_mem[tail_plus1[IDX_W-1:0]] <= '{need_to_wb: enq1_need_to_wb,
                                           lrd: enq1_lrd, prd: enq1_prd};
    end
  end

  always_comb begin
    state_d       = state_q;
    head_d        = head_q;
    tail_d        = tail_q;
    walk_ptr_d    = walk_ptr_q;
    walk_end_d    = walk_end_q;
    walk0_valid_d = 1'b0;
    walk0_lrd_d   = '0;
    walk0_prd_d   = '0;
    walk1_valid_d = 1'b0;
    walk1_lrd_d   = '0;
    walk1_prd_d   = '0;
    walk_next1    = '0;
    ent0          = '0;
    ent1          = '0;

    unique case (state_q)
      ST_IDLE: begin
        head_d = head_commit;
        if (flush_valid) begin
          state_d    = ST_OVERWRITE_RAT;
          walk_ptr_d = head_commit;
          walk_end_d = flush_ptr;
        end else begin
          tail_d = tail_q + PTR_W'(enq0_valid) + PTR_W'(enq1_valid);
        end
      end
      ST_OVERWRITE_RAT: begin
        if (walk_ptr_q == walk_end_q) begin
          state_d = ST_IDLE;
          tail_d  = walk_end_q;
        end else begin
          state_d = ST_WALKING;
        end
      end
      ST_WALKING: begin
        if ((walk_ptr_q + PTR_ONE) != walk_end_q) walk_ptr_d = walk_ptr_q + PTR_TWO;
        else                                      walk_ptr_d = walk_ptr_q + PTR_ONE;
        if (walk_ptr_d == walk_end_q) begin
          state_d = ST_IDLE;
          tail_d  = walk_end_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Walk slots are registered: the pair shown in a WALKING cycle is looked
    // up one edge early from the walk pointer that cycle will hold.
    if (state_d == ST_WALKING) begin
      walk_next1    = walk_ptr_d + PTR_ONE;
      ent0          = hist_mem[walk_ptr_d[IDX_W-1:0]];
      ent1          = hist_mem[walk_next1[IDX_W-1:0]];
      walk0_valid_d = ent0.need_to_wb;
      walk0_lrd_d   = ent0.lrd;
      walk0_prd_d   = ent0.prd;
      if (walk_next1 != walk_end_d) begin
        walk1_valid_d = ent1.need_to_wb;
        walk1_lrd_d   = ent1.lrd;
        walk1_prd_d   = ent1.prd;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      head_q        <= '0;
      tail_q        <= '0;
      walk_ptr_q    <= '0;
      walk_end_q    <= '0;
      walk0_valid_q <= 1'b0;
      walk0_lrd_q   <= '0;
      walk0_prd_q   <= '0;
      walk1_valid_q <= 1'b0;
      walk1_lrd_q   <= '0;
      walk1_prd_q   <= '0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      walk_ptr_q    <= walk_ptr_d;
      walk_end_q    <= walk_end_d;
      walk0_valid_q <= walk0_valid_d;
      walk0_lrd_q   <= walk0_lrd_d;
      walk0_prd_q   <= walk0_prd_d;
      walk1_valid_q <= walk1_valid_d;
      walk1_lrd_q   <= walk1_lrd_d;
      walk1_prd_q   <= walk1_prd_d;
    end
  end

  assign rob_state       = state_q;
  assign walk_busy       = (state_q != ST_IDLE);
  assign enq_ready       = (state_q == ST_IDLE) && (count <= CNT_ROOM_2);
  assign enq_tail_ptr    = tail_q;
  assign rob_walk0_valid = walk0_valid_q;
  assign rob_walk0_lrd   = walk0_lrd_q;
  assign rob_walk0_prd   = walk0_prd_q;
  assign rob_walk1_valid = walk1_valid_q;
  assign rob_walk1_lrd   = walk1_lrd_q;
  assign rob_walk1_prd   = walk1_prd_q;

endmodule

// File: tb/tb_rob_walk_ctrl.sv
// Directed bench for rob_walk_ctrl (ROB_DEPTH 64, PTR_W 7).
module tb_rob_walk_ctrl;

  localparam int unsigned LREG_W = 5;
  localparam int unsigned PREG_W = 6;
  localparam int unsigned PTR_W  = 7;

  logic              clock;
  logic              reset_n;
  logic              enq0_valid, enq0_need_to_wb;
  logic [LREG_W-1:0] enq0_lrd;
  logic [PREG_W-1:0] enq0_prd;
  logic              enq1_valid, enq1_need_to_wb;
  logic [LREG_W-1:0] enq1_lrd;
  logic [PREG_W-1:0] enq1_prd;
  logic              enq_ready;
  logic [PTR_W-1:0]  enq_tail_ptr;
  logic [1:0]        commit_cnt;
  logic              flush_valid;
  logic [PTR_W-1:0]  flush_ptr;
  logic [1:0]        rob_state;
  logic              rob_walk0_valid, rob_walk1_valid;
  logic [LREG_W-1:0] rob_walk0_lrd, rob_walk1_lrd;
  logic [PREG_W-1:0] rob_walk0_prd, rob_walk1_prd;
  logic              walk_busy;

  int checks = 0;
  int errors = 0;

  rob_walk_ctrl #(
    .ROB_DEPTH(64),
    .PREG_W   (PREG_W),
    .LREG_W   (LREG_W),
    .PTR_W    (PTR_W)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enq0_valid     (enq0_valid),
    .enq0_need_to_wb(enq0_need_to_wb),
    .enq0_lrd       (enq0_lrd),
    .enq0_prd       (enq0_prd),
    .enq1_valid     (enq1_valid),
    .enq1_need_to_wb(enq1_need_to_wb),
    .enq1_lrd       (enq1_lrd),
    .enq1_prd       (enq1_prd),
    .enq_ready      (enq_ready),
    .enq_tail_ptr   (enq_tail_ptr),
    .commit_cnt     (commit_cnt),
    .flush_valid    (flush_valid),
    .flush_ptr      (flush_ptr),
    .rob_state      (rob_state),
    .rob_walk0_valid(rob_walk0_valid),
    .rob_walk0_lrd  (rob_walk0_lrd),
    .rob_walk0_prd  (rob_walk0_prd),
    .rob_walk1_valid(rob_walk1_valid),
    .rob_walk1_lrd  (rob_walk1_lrd),
    .rob_walk1_prd  (rob_walk1_prd),
    .walk_busy      (walk_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    enq0_valid = 0; enq0_need_to_wb = 0; enq0_lrd = '0; enq0_prd = '0;
    enq1_valid = 0; enq1_need_to_wb = 0; enq1_lrd = '0; enq1_prd = '0;
    commit_cnt = '0; flush_valid = 0; flush_ptr = '0;
  endtask

  task automatic enq(input logic v0, input logic wb0, input int l0, input int p0,
                     input logic v1, input logic wb1, input int l1, input int p1);
    enq0_valid = v0; enq0_need_to_wb = wb0; enq0_lrd = LREG_W'(l0); enq0_prd = PREG_W'(p0);
    enq1_valid = v1; enq1_need_to_wb = wb1; enq1_lrd = LREG_W'(l1); enq1_prd = PREG_W'(p1);
  endtask

  task automatic check_walk(input string tag, input logic v0, input int l0, input int p0,
                            input logic v1, input int l1, input int p1);
    check({tag, "_st"}, rob_state, 2);
    check({tag, "_v0"}, rob_walk0_valid, v0);
    check({tag, "_l0"}, rob_walk0_lrd, l0);
    check({tag, "_p0"}, rob_walk0_prd, p0);
    check({tag, "_v1"}, rob_walk1_valid, v1);
    if (v1) begin
      check({tag, "_l1"}, rob_walk1_lrd, l1);
      check({tag, "_p1"}, rob_walk1_prd, p1);
    end
  endtask

  initial begin
    quiet();
    reset_n = 0;
    #12 reset_n = 1;
    tick(); tick(); tick();
    check("rst_state", rob_state, 0);
    check("rst_v0", rob_walk0_valid, 0);
    check("rst_v1", rob_walk1_valid, 0);
    check("rst_ready", enq_ready, 1);
    check("rst_tail", enq_tail_ptr, 0);
    check("rst_busy", walk_busy, 0);

    // Five renames, flush at 4: four survivors walked as two pairs.
    enq(1, 1, 1, 33, 1, 1, 2, 34); tick();
    enq(1, 1, 1, 35, 1, 1, 3, 36); tick();
    enq(1, 1, 4, 37, 0, 0, 0, 0);  tick();
    check("t1_tail5", enq_tail_ptr, 5);
    quiet(); flush_valid = 1; flush_ptr = 7'd4; tick();
    quiet();
    check("t1_ovr", rob_state, 1);
    check("t1_ovr_v0", rob_walk0_valid, 0);
    check("t1_ovr_busy", walk_busy, 1);
    check("t1_ovr_ready", enq_ready, 0);
    tick(); check_walk("t1_w1", 1, 1, 33, 1, 2, 34);
    tick(); check_walk("t1_w2", 1, 1, 35, 1, 3, 36);
    tick();
    check("t1_idle", rob_state, 0);
    check("t1_idle_v0", rob_walk0_valid, 0);
    check("t1_tail4", enq_tail_ptr, 4);
    check("t1_ready", enq_ready, 1);

    // Slot 0 without need_to_wb: valid0 low, still a 2-entry step.
    enq(1, 0, 5, 40, 1, 1, 6, 41); commit_cnt = 2; tick();
    quiet(); commit_cnt = 2; tick();
    quiet(); flush_valid = 1; flush_ptr = 7'd6; tick();
    quiet();
    check("t2_ovr", rob_state, 1);
    tick(); check_walk("t2_w", 0, 5, 40, 1, 6, 41);
    tick();
    check("t2_idle", rob_state, 0);
    check("t2_tail", enq_tail_ptr, 6);

    // Flush at post-commit head, with an enqueue in the same cycle (dropped).
    commit_cnt = 2; flush_valid = 1; flush_ptr = 7'd6;
    enq(1, 1, 9, 9, 0, 0, 0, 0);
    tick();
    quiet();
    check("t3_ovr", rob_state, 1);
    check("t3_tail_hold", enq_tail_ptr, 6);
    tick();
    check("t3_idle", rob_state, 0);
    check("t3_v0", rob_walk0_valid, 0);
    check("t3_tail", enq_tail_ptr, 6);

    // Advance head and tail to 62.
    for (int i = 0; i < 28; i++) begin
      enq(1, 1, 12, 20, 1, 1, 13, 21);
      commit_cnt = (i == 0) ? 2'd0 : 2'd2;
      tick();
    end
    quiet(); commit_cnt = 2; tick();
    quiet();
    check("t4_tail62", enq_tail_ptr, 62);

    // Three survivors across the wrap: (62,63) then 64 alone.
    enq(1, 1, 7, 50, 1, 1, 8, 51);  tick();
    enq(1, 1, 9, 52, 1, 1, 10, 53); tick();
    check("t4_tail66", enq_tail_ptr, 66);
    quiet(); flush_valid = 1; flush_ptr = 7'd65; tick();
    quiet();
    check("t4_ovr", rob_state, 1);
    tick(); check_walk("t4_w1", 1, 7, 50, 1, 8, 51);
    tick(); check_walk("t4_w2", 1, 9, 52, 0, 0, 0);
    tick();
    check("t4_idle", rob_state, 0);
    check("t4_tail65", enq_tail_ptr, 65);
    enq(1, 1, 11, 54, 0, 0, 0, 0); tick();
    quiet();
    check("t4_tail66b", enq_tail_ptr, 66);

    // Fill to 63 entries (head 62).
    for (int i = 0; i < 29; i++) begin
      enq(1, 1, 14, 22, 1, 1, 15, 23);
      tick();
    end
    quiet();
    check("t5_tail124", enq_tail_ptr, 124);
    check("t5_ready62", enq_ready, 1);
    enq(1, 1, 16, 24, 0, 0, 0, 0); tick();
    quiet();
    check("t5_tail125", enq_tail_ptr, 125);
    check("t5_full_ready", enq_ready, 0);

    // Reset asserted in the middle of a WALKING cycle.
    flush_valid = 1; flush_ptr = 7'd66; tick();
    quiet(); tick();
    check_walk("t5_w1", 1, 7, 50, 1, 8, 51);
    #2 reset_n = 0;
    #1;
    check("t5_rst_state", rob_state, 0);
    check("t5_rst_v0", rob_walk0_valid, 0);
    check("t5_rst_v1", rob_walk1_valid, 0);
    check("t5_rst_l0", rob_walk0_lrd, 0);
    check("t5_rst_tail", enq_tail_ptr, 0);
    check("t5_rst_ready", enq_ready, 1);
    check("t5_rst_busy", walk_busy, 0);
    #2 reset_n = 1;
    tick();
    check("t5_post_state", rob_state, 0);
    check("t5_post_tail", enq_tail_ptr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
